// File: rtl/pwm_seq_pkg.sv
// Shared types and constants for the PWM fade sequencer and its per-channel stepper.
package pwm_seq_pkg;

  localparam int unsigned CH_NUM = 3;
  localparam int unsigned DUTY_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    HOLD   = 2'd2,
    FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/pwm_ramp_step.sv
// One saturating step of a duty value toward its target, evaluated at DUTY_W+1 bits
// so an upward step near full scale clamps instead of wrapping.
module pwm_ramp_step
  import pwm_seq_pkg::*;
(
  input  logic [DUTY_W-1:0] cur_i,
  input  logic [DUTY_W-1:0] tgt_i,
  input  logic [DUTY_W-1:0] step_i,
  output logic [DUTY_W-1:0] nxt_c
);

  logic [DUTY_W:0] up_c;
  logic [DUTY_W:0] gap_c;

  always_comb begin
    nxt_c = cur_i;
    up_c  = {1'b0, cur_i} + {1'b0, step_i};
    gap_c = '0;
    if (cur_i < tgt_i) begin
      nxt_c = (up_c >= {1'b0, tgt_i}) ? tgt_i : up_c[DUTY_W-1:0];
    end else if (cur_i > tgt_i) begin
      gap_c = {1'b0, cur_i} - {1'b0, tgt_i};
      nxt_c = (gap_c <= {1'b0, step_i}) ? tgt_i : (cur_i - step_i);
    end
  end

endmodule

// File: rtl/pwm_fade_sequencer.sv
// Steps three PWM duty values toward latched targets once per PWM period, holds for a
// programmed number of periods, then pulses done. Abort and reset end a fade without done.
module pwm_fade_sequencer
  import pwm_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              period_complete,
  input  logic [DUTY_W-1:0] target0,
  input  logic [DUTY_W-1:0] target1,
  input  logic [DUTY_W-1:0] target2,
  input  logic [DUTY_W-1:0] step,
  input  logic [DUTY_W-1:0] hold_periods,
  output logic [DUTY_W-1:0] duty0,
  output logic [DUTY_W-1:0] duty1,
  output logic [DUTY_W-1:0] duty2,
  output logic              timer_run,
  output logic              busy,
  output logic              done
);

  state_e                        state_q, state_d;
  logic [CH_NUM-1:0][DUTY_W-1:0] duty_q, duty_d;
  logic [CH_NUM-1:0][DUTY_W-1:0] tgt_q, tgt_d;
  logic [CH_NUM-1:0][DUTY_W-1:0] tgt_in_c;
  logic [CH_NUM-1:0][DUTY_W-1:0] step_res_c;
  logic [DUTY_W-1:0]             step_q, step_d;
  logic [DUTY_W-1:0]             hold_q, hold_d;
  logic [DUTY_W-1:0]             hold_cnt_q, hold_cnt_d;
  logic [DUTY_W-1:0]             hold_inc_c;
  logic                          busy_q, busy_d;
  logic                          timer_run_q, timer_run_d;
  logic                          done_q, done_d;
  logic                          all_at_tgt_c;
  logic                          start_at_tgt_c;

  assign tgt_in_c       = {target2, target1, target0};
  assign all_at_tgt_c   = (step_res_c == tgt_q);
  assign start_at_tgt_c = (duty_q == tgt_in_c);
  assign hold_inc_c     = hold_cnt_q + DUTY_W'(1);

  for (genvar ch = 0; ch < CH_NUM; ch++) begin : g_ch
    pwm_ramp_step u_ramp_step (
      .cur_i  (duty_q[ch]),
      .tgt_i  (tgt_q[ch]),
      .step_i (step_q),
      .nxt_c  (step_res_c[ch])
    );
  end

  // Next-state and registered-output logic; abort outranks start and period_complete.
  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    tgt_d      = tgt_q;
    step_d     = step_q;
    hold_d     = hold_q;
    hold_cnt_d = hold_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          tgt_d      = tgt_in_c;
          step_d     = (step == '0) ? DUTY_W'(1) : step;
          hold_d     = hold_periods;
          hold_cnt_d = '0;
          state_d    = start_at_tgt_c ? HOLD : RAMP;
        end
      end
      RAMP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (period_complete) begin
          duty_d = step_res_c;
          if (all_at_tgt_c) begin
            state_d    = HOLD;
            hold_cnt_d = '0;
          end
        end
      end
      HOLD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (hold_cnt_q == hold_q) begin
          state_d = FINISH;
        end else if (period_complete) begin
          hold_cnt_d = hold_inc_c;
          if (hold_inc_c == hold_q) begin
            state_d = FINISH;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d      = (state_d != IDLE);
    timer_run_d = (state_d != IDLE);
    done_d      = (state_d == FINISH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      duty_q      <= '0;
      tgt_q       <= '0;
      step_q      <= '0;
      hold_q      <= '0;
      hold_cnt_q  <= '0;
      busy_q      <= 1'b0;
      timer_run_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      duty_q      <= duty_d;
      tgt_q       <= tgt_d;
      step_q      <= step_d;
      hold_q      <= hold_d;
      hold_cnt_q  <= hold_cnt_d;
      busy_q      <= busy_d;
      timer_run_q <= timer_run_d;
      done_q      <= done_d;
    end
  end

  assign duty0     = duty_q[0];
  assign duty1     = duty_q[1];
  assign duty2     = duty_q[2];
  assign busy      = busy_q;
  assign timer_run = timer_run_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Self-checking bench for pwm_fade_sequencer: directed fade scenarios plus randomized
// sequences compared against a per-pulse arithmetic model of the duty trajectory.
module tb_pwm_fade_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, abort, period_complete;
  logic [7:0] target0, target1, target2, step, hold_periods;
  logic [7:0] duty0, duty1, duty2;
  logic       timer_run, busy, done;

  int checks   = 0;
  int failures = 0;
  int m_duty[3];

  always #5 clk = ~clk;

  pwm_fade_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .abort           (abort),
    .period_complete (period_complete),
    .target0         (target0),
    .target1         (target1),
    .target2         (target2),
    .step            (step),
    .hold_periods    (hold_periods),
    .duty0           (duty0),
    .duty1           (duty1),
    .duty2           (duty2),
    .timer_run       (timer_run),
    .busy            (busy),
    .done            (done)
  );

  function automatic int model_step(input int cur, input int tgt, input int s);
    int e;
    e = (s == 0) ? 1 : s;
    if (cur < tgt) return (cur + e > tgt) ? tgt : cur + e;
    if (cur > tgt) return (cur - e < tgt) ? tgt : cur - e;
    return cur;
  endfunction

  function automatic logic [23:0] pack3(input int a, input int b, input int c);
    return {8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    period_complete = 1'b1;
    cyc();
    period_complete = 1'b0;
  endtask

  task automatic drive_start(input int t0, input int t1, input int t2, input int s, input int h);
    target0 = 8'(t0); target1 = 8'(t1); target2 = 8'(t2);
    step = 8'(s); hold_periods = 8'(h);
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Loads known duties with a single large-step fade, bounded wait for completion.
  task automatic set_duties(input int a, input int b, input int c);
    drive_start(a, b, c, 255, 0);
    period_complete = 1'b1;
    for (int i = 0; i < 6 && busy; i++) cyc();
    period_complete = 1'b0;
    checks++;
    if (busy !== 1'b0 || {duty2, duty1, duty0} !== pack3(a, b, c)) begin
      failures++;
      $display("FAIL set_duties busy=%0b duties=%h expected busy=0 duties=%h", busy, {duty2, duty1, duty0}, pack3(a, b, c));
    end
    m_duty[0] = a; m_duty[1] = b; m_duty[2] = c;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; abort = 1'b0; period_complete = 1'b1;
    target0 = 8'd9; target1 = 8'd9; target2 = 8'd9; step = 8'd9; hold_periods = 8'd0;
    cyc(); cyc();
    checks++;
    if ({duty2, duty1, duty0, timer_run, busy, done} !== 27'd0) begin
      failures++;
      $display("FAIL reset_state got duties=%h tr=%0b busy=%0b done=%0b expected all 0", {duty2, duty1, duty0}, timer_run, busy, done);
    end
    reset = 1'b0; start = 1'b0; period_complete = 1'b0;
    cyc();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_release busy=%0b expected 0", busy); end
    m_duty = '{0, 0, 0};
  endtask

  task automatic test_fade_up();
    int e0, e2;
    drive_start(25, 50, 75, 10, 2);
    checks++;
    if (busy !== 1'b1 || timer_run !== 1'b1) begin
      failures++; $display("FAIL fade_up_start busy=%0b tr=%0b expected 1 1", busy, timer_run);
    end
    for (int k = 1; k <= 8; k++) begin
      pulse();
      e0 = (10 * k > 25) ? 25 : 10 * k;
      e2 = (10 * k > 75) ? 75 : 10 * k;
      checks++;
      if (duty0 !== 8'(e0) || duty2 !== 8'(e2) || done !== 1'b0) begin
        failures++; $display("FAIL fade_up_pulse%0d duty0=%0d duty2=%0d done=%0b expected %0d %0d 0", k, duty0, duty2, done, e0, e2);
      end
    end
    checks++;
    if (duty1 !== 8'd50) begin failures++; $display("FAIL fade_up_duty1 got %0d expected 50", duty1); end
    pulse();
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL fade_up_hold1 done=%0b expected 0", done); end
    pulse();
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL fade_up_done done=%0b busy=%0b expected 1 1", done, busy); end
    cyc();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || timer_run !== 1'b0) begin
      failures++; $display("FAIL fade_up_end done=%0b busy=%0b tr=%0b expected 0 0 0", done, busy, timer_run);
    end
    m_duty = '{25, 50, 75};
  endtask

  task automatic test_fade_down();
    int exp_v[3] = '{60, 30, 10};
    set_duties(90, 90, 90);
    drive_start(10, 10, 10, 30, 0);
    for (int k = 0; k < 3; k++) begin
      pulse();
      checks++;
      if ({duty2, duty1, duty0} !== pack3(exp_v[k], exp_v[k], exp_v[k])) begin
        failures++; $display("FAIL fade_down_%0d got %h expected %h", k, {duty2, duty1, duty0}, pack3(exp_v[k], exp_v[k], exp_v[k]));
      end
    end
    cyc();
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL fade_down_done done=%0b expected 1", done); end
    cyc();
    m_duty = '{10, 10, 10};
  endtask

  task automatic test_no_wrap();
    set_duties(250, 250, 250);
    drive_start(255, 255, 255, 10, 0);
    pulse();
    checks++;
    if ({duty2, duty1, duty0} !== 24'hFFFFFF) begin
      failures++; $display("FAIL no_wrap got %h expected ffffff", {duty2, duty1, duty0});
    end
    cyc(); cyc();
    m_duty = '{255, 255, 255};
  endtask

  task automatic test_step_zero();
    set_duties(0, 0, 0);
    drive_start(3, 3, 3, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      pulse();
      checks++;
      if ({duty2, duty1, duty0} !== pack3(k, k, k)) begin
        failures++; $display("FAIL step_zero_%0d got %h expected %h", k, {duty2, duty1, duty0}, pack3(k, k, k));
      end
    end
    cyc(); cyc();
    m_duty = '{3, 3, 3};
  endtask

  task automatic test_equal_targets();
    bit seen = 0;
    set_duties(40, 41, 42);
    drive_start(40, 41, 42, 5, 0);
    if (done) seen = 1;
    if (!seen) begin cyc(); if (done) seen = 1; end
    checks++;
    if (!seen || {duty2, duty1, duty0} !== pack3(40, 41, 42)) begin
      failures++; $display("FAIL equal_targets done_seen=%0b duties=%h expected 1 %h", seen, {duty2, duty1, duty0}, pack3(40, 41, 42));
    end
    cyc(); cyc();
  endtask

  task automatic test_start_while_busy();
    drive_start(100, 100, 100, 1, 0);
    start = 1'b1; target0 = 8'd0; target1 = 8'd0; target2 = 8'd0; step = 8'd200;
    for (int k = 1; k <= 3; k++) begin
      pulse();
      checks++;
      if ({duty2, duty1, duty0} !== pack3(40 + k, 41 + k, 42 + k)) begin
        failures++; $display("FAIL start_busy_%0d got %h expected %h", k, {duty2, duty1, duty0}, pack3(40 + k, 41 + k, 42 + k));
      end
    end
    start = 1'b0; abort = 1'b1;
    cyc();
    abort = 1'b0;
    m_duty = '{43, 44, 45};
  endtask

  task automatic test_abort_ramp();
    drive_start(200, 200, 200, 7, 1);
    pulse(); pulse();
    abort = 1'b1; period_complete = 1'b1;
    cyc();
    abort = 1'b0; period_complete = 1'b0;
    checks++;
    if ({duty2, duty1, duty0} !== pack3(57, 58, 59) || busy !== 1'b0 || timer_run !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL abort_ramp duties=%h busy=%0b tr=%0b done=%0b expected %h 0 0 0", {duty2, duty1, duty0}, busy, timer_run, done, pack3(57, 58, 59));
    end
    for (int k = 0; k < 4; k++) begin
      period_complete = 1'(k % 2);
      cyc();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || {duty2, duty1, duty0} !== pack3(57, 58, 59)) begin
        failures++; $display("FAIL abort_idle_%0d done=%0b busy=%0b duties=%h expected 0 0 %h", k, done, busy, {duty2, duty1, duty0}, pack3(57, 58, 59));
      end
    end
    period_complete = 1'b0;
    m_duty = '{57, 58, 59};
  endtask

  task automatic test_reset_hold();
    drive_start(57, 58, 59, 3, 5);
    pulse();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL reset_hold_busy busy=%0b expected 1", busy); end
    reset = 1'b1; period_complete = 1'b1; start = 1'b1;
    cyc();
    reset = 1'b0; period_complete = 1'b0; start = 1'b0;
    checks++;
    if ({duty2, duty1, duty0} !== 24'd0 || busy !== 1'b0 || timer_run !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL reset_hold duties=%h busy=%0b tr=%0b done=%0b expected 0 0 0 0", {duty2, duty1, duty0}, busy, timer_run, done);
    end
    cyc();
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_hold_nodone done=%0b expected 0", done); end
    m_duty = '{0, 0, 0};
  endtask

  // One fade with random gaps and mid-sequence input noise, checked every cycle.
  task automatic run_seq(input int t0, input int t1, input int t2, input int s, input int h);
    logic [23:0] exp_q[$];
    logic [23:0] cur_exp;
    int cur[3];
    int gap;
    cur = m_duty;
    while (cur[0] != t0 || cur[1] != t1 || cur[2] != t2) begin
      cur[0] = model_step(cur[0], t0, s);
      cur[1] = model_step(cur[1], t1, s);
      cur[2] = model_step(cur[2], t2, s);
      exp_q.push_back(pack3(cur[0], cur[1], cur[2]));
    end
    cur_exp = pack3(m_duty[0], m_duty[1], m_duty[2]);
    drive_start(t0, t1, t2, s, h);
    for (int n = 0; n <= exp_q.size() + h; n++) begin
      gap = (n == exp_q.size() + h) ? 0 : int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        target0 = 8'($urandom); step = 8'($urandom); start = 1'($urandom_range(0, 1));
        cyc();
        start = 1'b0;
        checks++;
        if ({duty2, duty1, duty0} !== cur_exp || busy !== 1'b1 || timer_run !== 1'b1 || done !== 1'b0) begin
          failures++; $display("FAIL rand_gap duties=%h busy=%0b tr=%0b done=%0b expected %h 1 1 0", {duty2, duty1, duty0}, busy, timer_run, done, cur_exp);
        end
      end
      if (n == exp_q.size() + h) break;
      pulse();
      if (n < exp_q.size()) cur_exp = exp_q[n];
      checks++;
      if ({duty2, duty1, duty0} !== cur_exp || done !== 1'(h > 0 && n == exp_q.size() + h - 1)) begin
        failures++; $display("FAIL rand_pulse%0d duties=%h done=%0b expected %h %0b", n, {duty2, duty1, duty0}, done, cur_exp, (h > 0 && n == exp_q.size() + h - 1));
      end
    end
    if (h == 0) begin
      cyc();
      checks++;
      if (done !== 1'b1) begin failures++; $display("FAIL rand_done0 done=%0b expected 1", done); end
    end
    cyc();
    checks++;
    if (busy !== 1'b0 || timer_run !== 1'b0 || done !== 1'b0 || {duty2, duty1, duty0} !== pack3(t0, t1, t2)) begin
      failures++; $display("FAIL rand_end busy=%0b tr=%0b done=%0b duties=%h expected 0 0 0 %h", busy, timer_run, done, {duty2, duty1, duty0}, pack3(t0, t1, t2));
    end
    m_duty = '{t0, t1, t2};
  endtask

  task automatic test_random();
    int s;
    for (int it = 0; it < 25; it++) begin
      s = (it % 5 == 0) ? 0 : int'($urandom_range(1, 60));
      run_seq(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              s, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_fade_up();
    test_fade_down();
    test_no_wrap();
    test_step_zero();
    test_equal_targets();
    test_start_while_busy();
    test_abort_ramp();
    test_reset_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
